sl_preceptron_weight_loader: RTL

Host-side initiator for the perceptron's external weight-memory port. It accepts a byte stream of `VECTOR_LENGTH` weights over a valid/ready handshake and writes them to consecutive SRAM addresses from a programmable base. It backs off whenever the MAC owns the memory bus, and optionally reads the block back to verify a checksum. It sits between the host/DMA stream and the `mem_wen`/`mem_ren`/`mem_addr`/`mem_wdata`/`mem_rdata` port of the perceptron top.

---
 rtl/sl_preceptron_weight_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sl_preceptron_weight_loader.sv
// Streams VECTOR_LENGTH weight bytes into the perceptron SRAM from a base address.
// Optional readback checksum verification is built when WEIGHT_LOADER_VERIFY_EN is defined.
module sl_preceptron_weight_loader #(
   parameter int unsigned WEIGHTS_WIDTH  = 8,
   parameter int unsigned MEM_ADDR_WIDTH = 16,
   parameter int unsigned VECTOR_LENGTH  = 64,
   parameter int unsigned CSUM_WIDTH     = WEIGHTS_WIDTH + $clog2(VECTOR_LENGTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
   input  logic                      abort,
   input  logic                      s_valid,
   input  logic [WEIGHTS_WIDTH-1:0]  s_data,
   output logic                      s_ready,
   input  logic                      mem_busy,
   output logic                      mem_wen,
   output logic                      mem_ren,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [WEIGHTS_WIDTH-1:0]  mem_wdata,
   input  logic [WEIGHTS_WIDTH-1:0]  mem_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [CSUM_WIDTH-1:0]     checksum
);

   localparam int unsigned CNT_W = $clog2(VECTOR_LENGTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LENGTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_VERIFY,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                    state;
   logic [MEM_ADDR_WIDTH-1:0] base_q;
   logic [CNT_W-1:0]          wcnt;
   logic [CSUM_WIDTH-1:0]     csum_q;
   logic                      wr_beat;
   logic                      rd_issue;

`ifdef WEIGHT_LOADER_VERIFY_EN
   logic [CNT_W-1:0]          rcnt;
   logic [CSUM_WIDTH-1:0]     rsum;
   logic                      rd_pend;
   logic                      err_q;
`endif

   // Strobes are combinational so a beat is written in the cycle it is accepted.
   assign s_ready = (state == S_WRITE) && !mem_busy && !abort;
   assign wr_beat = s_ready && s_valid;

`ifdef WEIGHT_LOADER_VERIFY_EN
   assign rd_issue = (state == S_VERIFY) && !mem_busy && !abort;
   assign error    = err_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;
   assign rd_issue     = 1'b0;
   assign error        = 1'b0;
`endif

   assign mem_wen  = wr_beat;
   assign mem_ren  = rd_issue;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign checksum = csum_q;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (wr_beat) begin
         mem_addr  = base_q + MEM_ADDR_WIDTH'(wcnt);
         mem_wdata = s_data;
      end
`ifdef WEIGHT_LOADER_VERIFY_EN
      else if (rd_issue) begin
         mem_addr = base_q + MEM_ADDR_WIDTH'(rcnt);
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         base_q  <= '0;
         wcnt    <= '0;
         csum_q  <= '0;
`ifdef WEIGHT_LOADER_VERIFY_EN
         rcnt    <= '0;
         rsum    <= '0;
         rd_pend <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else if (abort) begin
         state   <= S_IDLE;
`ifdef WEIGHT_LOADER_VERIFY_EN
         rd_pend <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  wcnt   <= '0;
                  csum_q <= '0;
`ifdef WEIGHT_LOADER_VERIFY_EN
                  rcnt   <= '0;
                  rsum   <= '0;
                  err_q  <= 1'b0;
`endif
                  state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (wr_beat) begin
                  csum_q <= csum_q + CSUM_WIDTH'(s_data);
                  wcnt   <= wcnt + 1'b1;
                  if (wcnt == LAST_IDX) begin
`ifdef WEIGHT_LOADER_VERIFY_EN
                     state <= S_VERIFY;
`else
                     state <= S_DONE;
`endif
                  end
               end
            end
`ifdef WEIGHT_LOADER_VERIFY_EN
            S_VERIFY: begin
               // Read data lands one cycle after its strobe, regardless of mem_busy then.
               rd_pend <= rd_issue;
               if (rd_pend) rsum <= rsum + CSUM_WIDTH'(mem_rdata);
               if (rd_issue) begin
                  rcnt <= rcnt + 1'b1;
                  if (rcnt == LAST_IDX) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               rd_pend <= 1'b0;
               rsum    <= rsum + CSUM_WIDTH'(mem_rdata);
               if ((rsum + CSUM_WIDTH'(mem_rdata)) != csum_q) err_q <= 1'b1;
               state   <= S_DONE;
            end
`endif
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
